// File: rtl/ibex_multdiv_iter.sv
// Iterative multiplier/divider for the EX stage.
// Multiplies MUL_STEP bits per cycle (shift-add) and divides one quotient
// bit per cycle (restoring) on magnitudes, then applies the sign fix-up in a
// single FIX cycle. Request/response use valid/ready; kill_i flushes an op.
module ibex_multdiv_iter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 1,
    parameter bit          DIT      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             kill_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] resp_data_o,
    output logic             busy_o
);

    localparam int unsigned PW       = 2 * WIDTH;
    localparam int unsigned CNT_W    = $clog2(WIDTH) + 1;
    localparam int unsigned MUL_ITER = WIDTH / MUL_STEP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q;
    logic [2:0]         op_q;
    logic               sa_q;
    logic               sb_q;
    logic               b_zero_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PW-1:0]      mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [PW-1:0]      acc_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   resp_data_q;

    // Request-side decode: signedness per op and operand magnitudes
    logic               sa_c;
    logic               sb_c;
    logic               is_div_c;
    logic               b_is_zero_c;
    logic [WIDTH-1:0]   a_mag_c;
    logic [WIDTH-1:0]   b_mag_c;

    always_comb begin
        is_div_c    = op_i[2];
        sa_c        = ((op_i == 3'd1) | (op_i == 3'd2) | (op_i == 3'd4) | (op_i == 3'd6))
                      & op_a_i[WIDTH-1];
        sb_c        = ((op_i == 3'd1) | (op_i == 3'd4) | (op_i == 3'd6)) & op_b_i[WIDTH-1];
        b_is_zero_c = (op_b_i == '0);
        a_mag_c     = sa_c ? -op_a_i : op_a_i;
        b_mag_c     = sb_c ? -op_b_i : op_b_i;
    end

    // Multiplier step: add |a| shifted by each set bit of the low multiplier digit
    logic [PW-1:0] pp_c;
    logic [PW-1:0] acc_sum_c;

    always_comb begin
        pp_c = '0;
        for (int i = 0; i < int'(MUL_STEP); i++) begin
            if (mplier_q[i]) begin
                pp_c = pp_c + (mcand_q << i);
            end
        end
        acc_sum_c = acc_q + pp_c;
    end

    // Divider step: trial subtract of the divisor from the shifted partial remainder
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH+1:0] trial_c;
    logic [WIDTH-1:0] rem_nxt_c;
    logic             q_bit_c;
    logic             unused_trial_bit;

    always_comb begin
        shifted_c = {rem_q, quo_q[WIDTH-1]};
        trial_c   = {1'b0, shifted_c} - {2'b00, divisor_q};
        q_bit_c   = ~trial_c[WIDTH+1];
        rem_nxt_c = trial_c[WIDTH+1] ? shifted_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
    end

    // A non-negative trial result is below the divisor, so its top bit is always zero
    assign unused_trial_bit = trial_c[WIDTH];

    // Sign fix-up and result selection for the FIX cycle
    logic [PW-1:0]    prod_fix_c;
    logic [WIDTH-1:0] quo_fix_c;
    logic [WIDTH-1:0] rem_fix_c;
    logic [WIDTH-1:0] result_c;

    always_comb begin
        prod_fix_c = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_fix_c  = ((sa_q ^ sb_q) & ~b_zero_q) ? -quo_q : quo_q;
        rem_fix_c  = sa_q ? -rem_q : rem_q;
        case (op_q)
            3'd0:                result_c = prod_fix_c[WIDTH-1:0];
            3'd1, 3'd2, 3'd3:    result_c = prod_fix_c[PW-1:WIDTH];
            3'd4, 3'd5:          result_c = quo_fix_c;
            default:             result_c = rem_fix_c;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            b_zero_q    <= 1'b0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            divisor_q   <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            resp_data_q <= '0;
        end else if (kill_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        op_q      <= op_i;
                        sa_q      <= sa_c;
                        sb_q      <= sb_c;
                        b_zero_q  <= b_is_zero_c;
                        mcand_q   <= {{WIDTH{1'b0}}, a_mag_c};
                        mplier_q  <= b_mag_c;
                        acc_q     <= '0;
                        divisor_q <= b_mag_c;
                        quo_q     <= a_mag_c;
                        rem_q     <= '0;
                        cnt_q     <= is_div_c ? CNT_W'(WIDTH) : CNT_W'(MUL_ITER);
                        if (!DIT && is_div_c && b_is_zero_c) begin
                            // Divide by zero resolves without iterating
                            resp_data_q <= op_i[1] ? op_a_i : '1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= COMP;
                        end
                    end
                end
                COMP: begin
                    if (op_q[2]) begin
                        rem_q <= rem_nxt_c;
                        quo_q <= {quo_q[WIDTH-2:0], q_bit_c};
                    end else begin
                        acc_q    <= acc_sum_c;
                        mcand_q  <= mcand_q << MUL_STEP;
                        mplier_q <= mplier_q >> MUL_STEP;
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                    if ((cnt_q == CNT_W'(1)) || (!DIT && !op_q[2] && (mplier_q == '0))) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    resp_data_q <= result_c;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (resp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state_q == IDLE) & ~kill_i;
    assign resp_valid_o = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign resp_data_o  = resp_data_q;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed bench for ibex_multdiv_iter: four instances covering
// MUL_STEP 1/4 with DIT on/off, result and latency checks per op.
module tb_ibex_multdiv_iter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [3:0]  kill;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready;
    logic [3:0]  busy;
    logic [31:0] resp_data [4];

    int checks = 0;
    int errors = 0;

    // Instance 0: step 1 DIT 1; 1: step 1 DIT 0; 2: step 4 DIT 1; 3: step 4 DIT 0
    for (genvar g = 0; g < 4; g++) begin : g_dut
        ibex_multdiv_iter #(
            .WIDTH    (32),
            .MUL_STEP ((g >= 2) ? 4 : 1),
            .DIT      ((g % 2 == 0) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_valid_i  (req_valid[g]),
            .req_ready_o  (req_ready[g]),
            .op_i         (op),
            .op_a_i       (op_a),
            .op_b_i       (op_b),
            .kill_i       (kill[g]),
            .resp_valid_o (resp_valid[g]),
            .resp_ready_i (resp_ready[g]),
            .resp_data_o  (resp_data[g]),
            .busy_o       (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed 0x%0h, expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    // Called 1 time unit after the accept edge; counts edges until resp_valid
    task automatic wait_valid(input int d, output int lat);
        lat = 1;
        while (resp_valid[d] !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input int d, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_d,
                          input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        op = o;
        op_a = a;
        op_b = b;
        resp_ready[d] = 1'b1;
        req_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        wait_valid(d, lat);
        check(tag, "data", resp_data[d], exp_d);
        check(tag, "lat", 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
        check(tag, "idle", {30'd0, busy[d], resp_valid[d]}, 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        rst_n = 1'b0;
        op = 3'd0;
        op_a = '0;
        op_b = '0;
        req_valid = '0;
        kill = '0;
        resp_ready = '1;

        // Reset state
        #2;
        check("reset", "valid", 32'(resp_valid), 32'd0);
        check("reset", "busy", 32'(busy), 32'd0);
        check("reset", "data0", resp_data[0], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset", "ready", 32'(req_ready), 32'hF);

        // Multiply, step 1, full latency
        run_op(0, 3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7_m3");
        run_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min");
        run_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu_m1");
        run_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_max");

        // Divide and remainder, signed and unsigned
        run_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");
        run_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");
        run_op(0, 3'd5, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
        run_op(0, 3'd7, 32'd100, 32'd7, 32'd2,  34, "remu_100_7");

        // Overflow and divide by zero with data-independent timing
        run_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "div_ovf");
        run_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34, "rem_ovf");
        run_op(0, 3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 34, "div_m5_0_dit");
        run_op(0, 3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 34, "rem_m5_0_dit");

        // Early exits without DIT
        run_op(1, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_5_0");
        run_op(1, 3'd6, 32'd5, 32'd0, 32'd5,         1, "rem_5_0");
        run_op(1, 3'd0, 32'h0000_1234, 32'd0, 32'd0, 3, "mul_x_0");
        run_op(1, 3'd0, 32'd3, 32'd2, 32'd6,         5, "mul_3_2");

        // Four multiplier bits per cycle
        run_op(2, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080, 10, "mul_s4");
        run_op(2, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 10, "mulh_s4");
        run_op(3, 3'd0, 32'h1234_5678, 32'd0, 32'd0,  3, "mul_s4_x_0");
        run_op(3, 3'd0, 32'd5, 32'd3, 32'd15,         4, "mul_s4_5_3");

        // Kill mid-COMP: no response afterwards
        @(negedge clk);
        op = 3'd0; op_a = 32'd7; op_b = 32'd3; req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("kill_comp", "busy_before", 32'(busy[0]), 32'd1);
        kill[0] = 1'b1;
        @(posedge clk);
        #1;
        kill[0] = 1'b0;
        check("kill_comp", "busy_after", 32'(busy[0]), 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid[0] === 1'b1) seen++;
        end
        check("kill_comp", "stale_resp", 32'(seen), 32'd0);

        // Kill dominates a request in IDLE
        @(negedge clk);
        req_valid[0] = 1'b1; kill[0] = 1'b1;
        #1;
        check("kill_idle", "ready", 32'(req_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0; kill[0] = 1'b0;
        check("kill_idle", "busy", 32'(busy[0]), 32'd0);

        // Response stall in DONE: data held while inputs change
        @(negedge clk);
        op = 3'd5; op_a = 32'd100; op_b = 32'd7; resp_ready[0] = 1'b0; req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0; op = 3'd4; op_a = 32'hDEAD_BEEF; op_b = 32'd1;
        wait_valid(0, lat);
        check("stall", "lat", 32'(lat), 32'd34);
        check("stall", "data", resp_data[0], 32'd14);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall", "hold", {resp_valid[0], req_ready[0], resp_data[0][29:0]},
                  {2'b10, 30'd14});
        end
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("stall", "released", {30'd0, busy[0], resp_valid[0]}, 32'd0);
        run_op(0, 3'd7, 32'd100, 32'd7, 32'd2, 34, "remu_after_stall");

        // Kill in DONE with resp_ready in the same cycle
        @(negedge clk);
        op = 3'd0; op_a = 32'd6; op_b = 32'd7; resp_ready[0] = 1'b0; req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_valid(0, lat);
        check("kill_done", "data", resp_data[0], 32'd42);
        kill[0] = 1'b1; resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        kill[0] = 1'b0;
        check("kill_done", "after", {30'd0, busy[0], resp_valid[0]}, 32'd0);

        // Asynchronous reset mid-op
        @(negedge clk);
        op = 3'd0; op_a = 32'd9; op_b = 32'd9; req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", "busy", 32'(busy[0]), 32'd0);
        check("async_rst", "data", resp_data[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid[0] === 1'b1) seen++;
        end
        check("async_rst", "no_resp", 32'(seen), 32'd0);
        run_op(0, 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, "div_100_m7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
